// File: rtl/reg_view_responder.sv
// reg_view_responder: shadows the CPU register file and serves a frozen snapshot
// (registers, PC, frame count) to a display initiator, refreshed on request.
module reg_view_responder #(
    parameter logic [8:0] PC_ADDR  = 9'd32,
    parameter logic [8:0] CNT_ADDR = 9'd33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [31:0] pc,
    input  logic [8:0]  addr,
    output logic [31:0] register_value,
    input  logic        finished_register,
    output logic        busy
);
    typedef enum logic {IDLE, COPY} state_t;
    state_t state, state_nxt;
    logic [31:0] live [32];
    logic [31:0] display [32];
    logic [4:0]  idx;
    logic        pending;
    logic [15:0] frame_cnt;
    logic [31:0] pc_snap;
    logic        last, start;
    logic [31:0] copy_data, rd_data;
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    // A request seen during a copy chains straight into the next copy at its last beat.
    always_comb begin
        last      = state == COPY && idx == 5'd31;
        start     = (state == IDLE || last) && (finished_register || pending);
        state_nxt = start ? COPY : last ? IDLE : state;
        copy_data = (wr_en && wr_idx == idx && idx != 5'd0) ? wr_data : live[idx];
        rd_data   = addr < 9'd32      ? display[addr[4:0]] :
                    addr == PC_ADDR  ? pc_snap :
                    addr == CNT_ADDR ? {16'h0, frame_cnt} : 32'h0;
    end
    assign busy = state == COPY;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                live[i]    <= 32'h0;
                display[i] <= 32'h0;
            end
            idx            <= 5'd0;
            pending        <= 1'b0;
            frame_cnt      <= 16'h0;
            pc_snap        <= 32'h0;
            register_value <= 32'h0;
        end else begin
            if (wr_en && wr_idx != 5'd0) live[wr_idx] <= wr_data;
            if (busy) begin
                display[idx] <= copy_data;
                idx          <= idx + 5'd1;
            end
            if (last) frame_cnt <= frame_cnt + 16'd1;
            if (start) begin
                idx     <= 5'd0;
                pc_snap <= pc;
            end
            pending <= start ? 1'b0 : (busy && finished_register) ? 1'b1 : pending;
            if (!busy) register_value <= rd_data;
        end
    end
endmodule

// File: tb/tb_reg_view_responder.sv
// tb_reg_view_responder: directed checks of snapshot copy, read decode, forwarding,
// request collapsing and asynchronous abort.
module tb_reg_view_responder;
    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_idx = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [8:0]  addr = 9'd0;
    logic [31:0] register_value;
    logic        finished_register = 1'b0;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cnt;

    reg_view_responder dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .pc(pc), .addr(addr), .register_value(register_value),
        .finished_register(finished_register), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [8:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        step();
        chk(tag, register_value, exp);
    endtask

    task automatic wr(input logic [4:0] i, input logic [31:0] d);
        wr_en = 1'b1; wr_idx = i; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic snap();
        finished_register = 1'b1;
        step();
        finished_register = 1'b0;
        chk("snap_busy", {31'h0, busy}, 32'h1);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
        chk("snap_done", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #1;
        chk("rst_rv", register_value, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        rd(9'd5, 32'h0, "rst_a5");
        rd(9'd33, 32'h0, "rst_a33");
        rd(9'd40, 32'h0, "rst_a40");
        chk("rst_busy2", {31'h0, busy}, 32'h0);

        // Basic snapshot and exact copy length
        wr(5'd3, 32'hDEADBEEF);
        pc = 32'h100;
        finished_register = 1'b1;
        step();
        finished_register = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
        chk("busy_len32", cnt, 32'd32);
        rd(9'd3, 32'hDEADBEEF, "a3");
        rd(9'd32, 32'h100, "a32_pc");
        rd(9'd33, 32'h1, "a33_cnt1");
        rd(9'd31, 32'h0, "a31");
        rd(9'd40, 32'h0, "a40_other");

        // Writes to x0 are dropped
        wr(5'd0, 32'h1234);
        snap();
        rd(9'd0, 32'h0, "a0_zero");
        rd(9'd33, 32'h2, "a33_cnt2");

        // Forwarding at idx 7 and frozen read data during copy
        rd(9'd3, 32'hDEADBEEF, "pre_freeze");
        finished_register = 1'b1;
        step();
        finished_register = 1'b0;
        repeat (7) step();
        wr_en = 1'b1; wr_idx = 5'd7; wr_data = 32'hA5A5A5A5; addr = 9'd33;
        step();
        wr_en = 1'b0;
        chk("frozen1", register_value, 32'hDEADBEEF);
        addr = 9'd40;
        step();
        chk("frozen2", register_value, 32'hDEADBEEF);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
        chk("fwd_done", {31'h0, busy}, 32'h0);
        rd(9'd7, 32'hA5A5A5A5, "a7_fwd");
        rd(9'd33, 32'h3, "a33_cnt3");

        // Three requests during one copy collapse into one chained copy
        finished_register = 1'b1;
        step();
        finished_register = 1'b0;
        pc = 32'h200;
        cnt = 0;
        while (busy && cnt < 100) begin
            finished_register = (cnt == 5 || cnt == 10 || cnt == 20);
            cnt++;
            step();
        end
        finished_register = 1'b0;
        chk("busy_len64", cnt, 32'd64);
        step();
        chk("no_third_copy", {31'h0, busy}, 32'h0);
        rd(9'd33, 32'h5, "a33_cnt5");
        rd(9'd32, 32'h200, "a32_pc2");

        // Asynchronous reset in the middle of a copy
        finished_register = 1'b1;
        step();
        finished_register = 1'b0;
        repeat (10) step();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_rv", register_value, 32'h0);
        #2 reset = 1'b0;
        rd(9'd33, 32'h0, "post_a33");
        rd(9'd3, 32'h0, "post_a3");
        rd(9'd32, 32'h0, "post_a32");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
